// File: rtl/day_index_counter.sv
// day_index_counter: zero-based day-of-year index source (0..MAX_DAY).
// The day advances from a run-switch prescaler and from debounced inc/dec
// pushbuttons. It raises a one-cycle day_upd pulse on every change and a
// wrapped pulse when an update crosses MAX_DAY<->0.
// Optional feature: define DAYCNT_AUTOREPEAT_EN to enable button auto-repeat
// (REPEAT_DELAY before the first extra step, then one every REPEAT_RATE).
//
// Button/tick handshake: step and tick are one-cycle registered pulses.
// The output stage consumes them in the cycle they are high. There is no
// back-pressure, so a pulse is never stalled and never repeated.
module day_index_counter #(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int MAX_DAY         = 119,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_run,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [6:0] day_idx,
    output logic       day_upd,
    output logic       wrapped
);

    localparam int PW      = $clog2(TICK_DIV);
    localparam int CW      = $clog2(DEBOUNCE_CYCLES + 1);
    // The sample that leaves B_IDLE/B_HELD is already the first stable one.
    localparam int DB_LAST = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
    localparam int RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(RMAX + 1);

    // 9-bit signed so that MAX_DAY+2 stays representable even at MAX_DAY=127.
    localparam logic signed [8:0] MAX_S = 9'(MAX_DAY);
    localparam logic signed [8:0] MOD_S = 9'(MAX_DAY + 1);

    // Elaboration-time parameter legality checks.
    if (TICK_DIV < 2) begin : g_bad_tick
        $error("TICK_DIV must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (MAX_DAY < 1 || MAX_DAY > 127) begin : g_bad_max
        $error("MAX_DAY must be in 1..127");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rpt
        $error("REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    typedef enum logic [1:0] {B_IDLE, B_DBP, B_HELD, B_DBR} bstate_t;

    logic [2:0] sync_a;
    logic [2:0] sync_b;
    logic       run_s;
    logic [1:0] lvl;      // [0] = inc, [1] = dec
    logic [1:0] step;     // [0] = inc, [1] = dec
    logic [PW-1:0] pcnt;
    logic       tick;
    logic signed [8:0] net;
    logic signed [8:0] sum;

    // Two-flop synchronizers for all asynchronous inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {btn_dec, btn_inc, sw_run};
            sync_b <= sync_a;
        end
    end

    assign run_s = sync_b[0];
    assign lvl   = sync_b[2:1];

    for (genvar b = 0; b < 2; b++) begin : g_btn
        bstate_t       state;
        logic [CW-1:0] cnt;
        logic          step_r;
`ifdef DAYCNT_AUTOREPEAT_EN
        logic [RW-1:0] rpt;
        logic          rpt_phase;   // 0 = initial delay, 1 = repeat rate
        logic [RW-1:0] rpt_last;
        assign rpt_last = rpt_phase ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
`endif

        // Debounce FSM; emits a one-cycle step on an accepted press.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= B_IDLE;
                cnt    <= '0;
                step_r <= 1'b0;
`ifdef DAYCNT_AUTOREPEAT_EN
                rpt       <= '0;
                rpt_phase <= 1'b0;
`endif
            end else begin
                step_r <= 1'b0;
`ifdef DAYCNT_AUTOREPEAT_EN
                // Outside B_HELD the repeat timer is parked, so every entry restarts the delay.
                if (state != B_HELD) begin
                    rpt       <= '0;
                    rpt_phase <= 1'b0;
                end
`endif
                case (state)
                    B_IDLE: begin
                        if (lvl[b]) begin
                            cnt <= '0;
                            if (DEBOUNCE_CYCLES == 1) begin
                                state  <= B_HELD;
                                step_r <= 1'b1;
                            end else begin
                                state <= B_DBP;
                            end
                        end
                    end
                    B_DBP: begin
                        if (!lvl[b]) begin
                            state <= B_IDLE;
                        end else if (cnt == CW'(DB_LAST)) begin
                            state  <= B_HELD;
                            step_r <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    B_HELD: begin
                        if (!lvl[b]) begin
                            cnt   <= '0;
                            state <= (DEBOUNCE_CYCLES == 1) ? B_IDLE : B_DBR;
                        end
`ifdef DAYCNT_AUTOREPEAT_EN
                        else if (rpt == rpt_last) begin
                            step_r    <= 1'b1;
                            rpt       <= '0;
                            rpt_phase <= 1'b1;
                        end else begin
                            rpt <= rpt + 1'b1;
                        end
`endif
                    end
                    B_DBR: begin
                        if (lvl[b]) begin
                            state <= B_HELD;
                        end else if (cnt == CW'(DB_LAST)) begin
                            state <= B_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= B_IDLE;
                endcase
            end
        end

        assign step[b] = step_r;
    end

    // Run-mode prescaler; a dropped run switch discards any partial period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!run_s) begin
                pcnt <= '0;
            end else if (pcnt == PW'(TICK_DIV - 1)) begin
                pcnt <= '0;
                tick <= 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    // Net change this cycle (-1..+2) and the unwrapped next value.
    always_comb begin
        net = $signed({8'd0, tick}) + $signed({8'd0, step[0]}) - $signed({8'd0, step[1]});
        sum = $signed({2'b00, day_idx}) + net;
    end

    // Registered day index with modulo reduction and change/wrap pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_idx <= '0;
            day_upd <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            day_upd <= 1'b0;
            wrapped <= 1'b0;
            if (net != 9'sd0) begin
                day_upd <= 1'b1;
                if (sum > MAX_S) begin
                    day_idx <= 7'(sum - MOD_S);
                    wrapped <= 1'b1;
                end else if (sum < 9'sd0) begin
                    day_idx <= 7'(sum + MOD_S);
                    wrapped <= 1'b1;
                end else begin
                    day_idx <= 7'(sum);
                end
            end
        end
    end

endmodule

// File: tb/tb_day_index_counter.sv
// Bench for day_index_counter with TICK_DIV=10, DEBOUNCE_CYCLES=4, MAX_DAY=119.
module tb_day_index_counter;

    localparam int TICK_DIV = 10;
    localparam int DEB      = 4;
    localparam int MAX_DAY  = 119;
    localparam int RD       = 20;
    localparam int RR       = 5;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       sw_run  = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [6:0] day_idx;
    logic       day_upd;
    logic       wrapped;

    int n_checks = 0;
    int n_fail   = 0;
    int n_upd    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_e;

    typedef struct {
        logic       inc;
        logic       dec;
        logic       upd;
        logic [6:0] exp_day;
        logic       exp_wrap;
    } vec_t;
    vec_t vecs[6];

    day_index_counter #(
        .TICK_DIV(TICK_DIV),
        .DEBOUNCE_CYCLES(DEB),
        .MAX_DAY(MAX_DAY),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_run(sw_run),
        .btn_inc(btn_inc),
        .btn_dec(btn_dec),
        .day_idx(day_idx),
        .day_upd(day_upd),
        .wrapped(wrapped)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int day, input logic w);
        exp_q.push_back({7'(day), w});
    endtask

    task automatic press(input logic inc, input logic dec, input int hold);
        btn_inc = inc;
        btn_dec = dec;
        step_edges(hold);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        step_edges(12);
    endtask

    // Scoreboard: every update pulse must match the oldest expected update.
    always @(negedge clk) begin
        if (day_upd === 1'b1) begin
            n_upd++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_upd: got day %0d wrapped %0d, expected no update",
                         day_idx, wrapped);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_update", {24'd0, day_idx, wrapped}, {24'd0, sb_e});
            end
        end else if (wrapped === 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wrap_without_upd: got wrapped 1, expected 0");
        end
    end

    initial begin
        int n0;
        vecs[0] = '{1'b0, 1'b1, 1'b1, 7'd0,   1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 7'd119, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 7'd119, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 7'd0,   1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 7'd119, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 7'd118, 1'b0};

        // Reset state
        #20;
        chk("reset_day", 32'(day_idx), 0);
        chk("reset_upd", 32'(day_upd), 0);
        chk("reset_wrap", 32'(wrapped), 0);

        // Single clean press right at reset release: update at edge 7
        step_edges(1);
        rst_n   = 1'b1;
        btn_inc = 1'b1;
        push_exp(1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step_edges(1);
            chk($sformatf("press_wait_e%0d", i), 32'(day_idx), 0);
        end
        step_edges(1);
        chk("press_day_e7", 32'(day_idx), 1);
        chk("press_upd_e7", 32'(day_upd), 1);
        chk("press_wrap_e7", 32'(wrapped), 0);
        step_edges(1);
        chk("press_upd_e8", 32'(day_upd), 0);
        btn_inc = 1'b0;
        step_edges(12);

        // Bounce shorter than the debounce window
        n0 = n_upd;
        btn_inc = 1'b1; step_edges(3);
        btn_inc = 1'b0; step_edges(1);
        btn_inc = 1'b1; step_edges(3);
        btn_inc = 1'b0; step_edges(15);
        chk("bounce_day", 32'(day_idx), 1);
        chk("bounce_no_upd", 32'(n_upd - n0), 0);

        // Table of presses: decrement wrap, simultaneous inc+dec, increment wrap
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].upd) push_exp(vecs[i].exp_day, vecs[i].exp_wrap);
            n0 = n_upd;
            press(vecs[i].inc, vecs[i].dec, 10);
            chk($sformatf("vec%0d_day", i), 32'(day_idx), 32'(vecs[i].exp_day));
            chk($sformatf("vec%0d_upd_count", i), 32'(n_upd - n0), 32'(vecs[i].upd));
        end

        // Run mode from 118: 119 at edge 13, 0 at edge 23
        sw_run = 1'b1;
        push_exp(119, 1'b0);
        push_exp(0, 1'b1);
        step_edges(12);
        chk("run_day_e12", 32'(day_idx), 118);
        step_edges(1);
        chk("run_day_e13", 32'(day_idx), 119);
        chk("run_upd_e13", 32'(day_upd), 1);
        step_edges(10);
        chk("run_day_e23", 32'(day_idx), 0);
        chk("run_wrap_e23", 32'(wrapped), 1);
        sw_run = 1'b0;
        step_edges(15);
        chk("run_stop_day", 32'(day_idx), 0);

        // Back to 118, then an inc step coinciding with a tick: 118 -> 0 at once
        push_exp(119, 1'b1);
        press(1'b0, 1'b1, 10);
        push_exp(118, 1'b0);
        press(1'b0, 1'b1, 10);
        chk("pre_coincide_day", 32'(day_idx), 118);
        n0 = n_upd;
        sw_run = 1'b1;
        step_edges(6);
        btn_inc = 1'b1;
        push_exp(0, 1'b1);
        step_edges(7);
        chk("coincide_day", 32'(day_idx), 0);
        chk("coincide_wrap", 32'(wrapped), 1);
        chk("coincide_upd", 32'(day_upd), 1);
        sw_run = 1'b0;
        step_edges(3);
        btn_inc = 1'b0;
        step_edges(15);
        chk("coincide_one_upd", 32'(n_upd - n0), 1);

        // Reset mid-debounce with the button held through release
        push_exp(1, 1'b0);
        press(1'b1, 1'b0, 10);
        push_exp(2, 1'b0);
        press(1'b1, 1'b0, 10);
        btn_inc = 1'b1;
        step_edges(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_day", 32'(day_idx), 0);
        chk("async_reset_upd", 32'(day_upd), 0);
        chk("async_reset_wrap", 32'(wrapped), 0);
        step_edges(2);
        rst_n = 1'b1;
        push_exp(1, 1'b0);
        step_edges(7);
        chk("rst_held_day_e7", 32'(day_idx), 1);
        chk("rst_held_upd_e7", 32'(day_upd), 1);
        step_edges(10);
        chk("rst_held_one_step", 32'(day_idx), 1);
        btn_inc = 1'b0;
        step_edges(12);

        // Long hold from day 0: single step, or auto-repeat when enabled
        rst_n = 1'b0;
        step_edges(2);
        rst_n = 1'b1;
        chk("hold_start_day", 32'(day_idx), 0);
        btn_inc = 1'b1;
        push_exp(1, 1'b0);
`ifdef DAYCNT_AUTOREPEAT_EN
        for (int k = 2; k <= 6; k++) push_exp(k, 1'b0);
`endif
        step_edges(47);
        btn_inc = 1'b0;
        step_edges(20);
`ifdef DAYCNT_AUTOREPEAT_EN
        chk("hold_day", 32'(day_idx), 6);
`else
        chk("hold_day", 32'(day_idx), 1);
`endif

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
